// File: rtl/max_btw_edge_remover.sv
// Scans an edge list for the highest-betweenness edge, removes it and
// returns the pruned list with all betweenness counts cleared.
module max_btw_edge_remover #(
  parameter int NODE_WIDTH = 4,
  parameter int BTW_WIDTH  = 4,
  parameter int MAX_EDGES  = 8,
  localparam int REC_W  = 2*NODE_WIDTH + BTW_WIDTH,
  localparam int LIST_W = REC_W*MAX_EDGES,
  localparam int IDX_W  = $clog2(MAX_EDGES),
  localparam int CNT_W  = $clog2(MAX_EDGES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:LIST_W-1]       edges_in,
  output logic                    busy,
  output logic                    done,
  output logic [0:LIST_W-1]       edges_out,
  output logic [2*NODE_WIDTH-1:0] removed_edge,
  output logic [IDX_W-1:0]        removed_idx,
  output logic                    none_found,
  output logic [CNT_W-1:0]        edges_left
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REMOVE
  } state_t;

  state_t state, state_nx;

  logic [0:LIST_W-1]     buffer;
  logic [0:LIST_W-1]     pruned;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      max_idx;
  logic [BTW_WIDTH-1:0]  max_btw;
  logic                  found;
  logic [CNT_W-1:0]      count;

  logic [REC_W-1:0]      cur;
  logic [NODE_WIDTH-1:0] cur_a;
  logic [NODE_WIDTH-1:0] cur_b;
  logic [BTW_WIDTH-1:0]  cur_btw;
  logic                  cur_valid;
  logic                  cur_better;
  logic                  last_slot;
  logic [REC_W-1:0]      max_rec;

  // The slot vector is ascending, so node_a lands in the record's MSBs.
  always_comb begin
    cur = buffer[int'(idx)*REC_W +: REC_W];
  end

  assign cur_a      = cur[REC_W-1 -: NODE_WIDTH];
  assign cur_b      = cur[BTW_WIDTH +: NODE_WIDTH];
  assign cur_btw    = cur[BTW_WIDTH-1:0];
  assign cur_valid  = cur_a != cur_b;
  assign cur_better = cur_valid && (!found || cur_btw > max_btw);
  assign last_slot  = idx == IDX_W'(MAX_EDGES-1);

  always_comb begin
    max_rec = buffer[int'(max_idx)*REC_W +: REC_W];
  end

  always_comb begin
    pruned = buffer;
    for (int s = 0; s < MAX_EDGES; s++) begin
      if (found && s == int'(max_idx)) begin
        pruned[s*REC_W +: REC_W] = '0;
      end
      pruned[s*REC_W + 2*NODE_WIDTH +: BTW_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (last_slot) begin
          state_nx = REMOVE;
        end
      end
      REMOVE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer       <= '0;
      idx          <= '0;
      max_idx      <= '0;
      max_btw      <= '0;
      found        <= 1'b0;
      count        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      edges_out    <= '0;
      removed_edge <= '0;
      removed_idx  <= '0;
      none_found   <= 1'b0;
      edges_left   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            buffer  <= edges_in;
            idx     <= '0;
            max_idx <= '0;
            max_btw <= '0;
            found   <= 1'b0;
            count   <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (cur_valid) begin
            count <= count + CNT_W'(1);
          end
          if (cur_better) begin
            max_btw <= cur_btw;
            max_idx <= idx;
            found   <= 1'b1;
          end
          if (!last_slot) begin
            idx <= idx + IDX_W'(1);
          end
        end
        REMOVE: begin
          buffer    <= pruned;
          edges_out <= pruned;
          if (found) begin
            removed_edge <= max_rec[REC_W-1 -: 2*NODE_WIDTH];
            removed_idx  <= max_idx;
            none_found   <= 1'b0;
            edges_left   <= count - CNT_W'(1);
          end else begin
            removed_edge <= '0;
            removed_idx  <= '0;
            none_found   <= 1'b1;
            edges_left   <= '0;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_btw_edge_remover.sv
// Directed and randomized checks of max_btw_edge_remover against a
// list-level reference model.
module tb_max_btw_edge_remover;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [0:95] edges_in;
  logic        busy;
  logic        done;
  logic [0:95] edges_out;
  logic [7:0]  removed_edge;
  logic [2:0]  removed_idx;
  logic        none_found;
  logic [3:0]  edges_left;

  int checks = 0;
  int errors = 0;

  logic [0:95] exp_out;
  logic [7:0]  exp_re;
  logic [2:0]  exp_ri;
  logic        exp_nf;
  logic [3:0]  exp_left;

  max_btw_edge_remover dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .edges_in     (edges_in),
    .busy         (busy),
    .done         (done),
    .edges_out    (edges_out),
    .removed_edge (removed_edge),
    .removed_idx  (removed_idx),
    .none_found   (none_found),
    .edges_left   (edges_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [0:95] put(input logic [0:95] v, input int s,
                                      input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [3:0] w);
    logic [0:95] r;
    r = v;
    r[s*12 +: 12] = {a, b, w};
    return r;
  endfunction

  // Reference: largest weight among valid edges, then its first holder.
  task automatic model(input logic [0:95] e);
    logic [11:0] r [8];
    int n;
    int best_w;
    int best;
    n = 0;
    best_w = -1;
    best = -1;
    for (int s = 0; s < 8; s++) begin
      r[s] = e[s*12 +: 12];
      if (r[s][11:8] != r[s][7:4]) begin
        n++;
        if (int'(r[s][3:0]) > best_w) best_w = int'(r[s][3:0]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      if (best < 0 && r[s][11:8] != r[s][7:4] && int'(r[s][3:0]) == best_w)
        best = s;
    end
    exp_out = '0;
    for (int s = 0; s < 8; s++) begin
      if (s != best) exp_out[s*12 +: 12] = {r[s][11:4], 4'h0};
    end
    exp_nf   = best < 0;
    exp_re   = exp_nf ? 8'h00 : r[best][11:4];
    exp_ri   = exp_nf ? 3'd0 : 3'(best);
    exp_left = exp_nf ? 4'd0 : 4'(n - 1);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_edges_out"}, 96'(edges_out), 96'(exp_out));
    chk({tag, "_removed_edge"}, 96'(removed_edge), 96'(exp_re));
    chk({tag, "_removed_idx"}, 96'(removed_idx), 96'(exp_ri));
    chk({tag, "_none_found"}, 96'(none_found), 96'(exp_nf));
    chk({tag, "_edges_left"}, 96'(edges_left), 96'(exp_left));
  endtask

  task automatic run_op(input string tag, input logic [0:95] e);
    int lat;
    model(e);
    @(negedge clk);
    edges_in = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges_in = {$urandom, $urandom, $urandom};
    chk({tag, "_busy"}, 96'(busy), 96'(1));
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 96'(lat), 96'(9));
    check_outs(tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 96'(done), 96'(0));
    chk({tag, "_busy_drop"}, 96'(busy), 96'(0));
    check_outs({tag, "_hold"});
  endtask

  function automatic logic [0:95] rand_list();
    logic [0:95] v;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] w;
    v = '0;
    for (int s = 0; s < 8; s++) begin
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      w = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                      : 4'($urandom_range(0, 15));
      v = put(v, s, a, b, w);
    end
    return v;
  endfunction

  logic [0:95] t1;
  logic [0:95] v;
  int ndone;
  int d1;
  int d2;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    edges_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_edges_out", 96'(edges_out), 96'(0));
    chk("rst_removed_edge", 96'(removed_edge), 96'(0));
    chk("rst_none_found", 96'(none_found), 96'(0));
    chk("rst_edges_left", 96'(edges_left), 96'(0));
    rst = 1'b0;

    t1 = '0;
    t1 = put(t1, 0, 4'd0, 4'd1, 4'd3);
    t1 = put(t1, 1, 4'd1, 4'd2, 4'd5);
    t1 = put(t1, 2, 4'd2, 4'd3, 4'd2);
    t1 = put(t1, 3, 4'd3, 4'd0, 4'd1);
    run_op("basic", t1);
    chk("basic_re_const", 96'(removed_edge), 96'(8'h12));
    chk("basic_ri_const", 96'(removed_idx), 96'(1));
    chk("basic_left_const", 96'(edges_left), 96'(3));

    v = '0;
    v = put(v, 0, 4'd0, 4'd1, 4'd7);
    v = put(v, 1, 4'd2, 4'd3, 4'd7);
    v = put(v, 2, 4'd4, 4'd5, 4'd7);
    run_op("tie", v);
    chk("tie_ri_const", 96'(removed_idx), 96'(0));
    chk("tie_re_const", 96'(removed_edge), 96'(8'h01));

    run_op("empty", '0);
    chk("empty_nf_const", 96'(none_found), 96'(1));

    v = '0;
    v = put(v, 5, 4'd1, 4'd4, 4'd0);
    v = put(v, 7, 4'd2, 4'd6, 4'd0);
    run_op("zero_btw", v);
    chk("zero_btw_ri_const", 96'(removed_idx), 96'(5));
    v = exp_out;
    run_op("feedback", v);
    chk("feedback_ri_const", 96'(removed_idx), 96'(7));
    chk("feedback_left_const", 96'(edges_left), 96'(0));

    for (int i = 0; i < 12; i++) begin
      v = rand_list();
      run_op($sformatf("rand%0d", i), v);
      if (i % 3 == 2) begin
        v = exp_out;
        run_op($sformatf("rand%0d_fb", i), v);
      end
    end

    // Reset in the middle of a scan.
    @(negedge clk);
    edges_in = t1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_done", 96'(done), 96'(0));
    chk("midrst_edges_out", 96'(edges_out), 96'(0));
    chk("midrst_removed_edge", 96'(removed_edge), 96'(0));
    chk("midrst_removed_idx", 96'(removed_idx), 96'(0));
    chk("midrst_none_found", 96'(none_found), 96'(0));
    chk("midrst_edges_left", 96'(edges_left), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 96'(ndone), 96'(0));
    run_op("after_rst", t1);

    // start held high: one done per accept, re-accepted in the done cycle.
    model(t1);
    @(negedge clk);
    edges_in = t1;
    start = 1'b1;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    start = 1'b0;
    chk("held_ndone", 96'(ndone), 96'(2));
    chk("held_first", 96'(d1), 96'(9));
    chk("held_second", 96'(d2), 96'(19));
    check_outs("held");
    repeat (12) @(negedge clk);
    chk("held_idle", 96'(busy), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_btw_edge_remover.md
Name: max_btw_edge_remover

Overview:
- Downstream neighbour of the edge-betweenness calculator in the Girvan-Newman pipeline.
- Takes the edge list annotated with betweenness counts and finds the edge with the highest count. Removes that edge from the list.
- Returns the pruned list with every betweenness field cleared, ready for the next shortest-path / betweenness iteration.
- Sequential scanner: one edge record per clock, start/done handshake.

Parameters:
NODE_WIDTH, 4, bits per node id
BTW_WIDTH, 4, bits per betweenness count
MAX_EDGES, 8, edge slots in the list
REC_W, 2*NODE_WIDTH+BTW_WIDTH (derived, 12), bits per edge record

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
edges_in  in  [0:REC_W*MAX_EDGES-1]  edge list; slot s = bits [s*REC_W +: REC_W] = {node_a, node_b, btw}, node_a at the lowest index
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle pulse; outputs below valid from this cycle until next start
edges_out  out  [0:REC_W*MAX_EDGES-1]  pruned list, same format, all btw fields 0
removed_edge  out  2*NODE_WIDTH  {node_a,node_b} of the removed edge
removed_idx  out  clog2(MAX_EDGES)  slot index of the removed edge
none_found  out  1  no valid edge in the list; nothing removed
edges_left  out  clog2(MAX_EDGES+1)  valid edges remaining after removal

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; internal buffer, max register and index are cleared.
  - All outputs go to 0.
  - A reset mid-scan abandons the operation; no done pulse is produced.
- Valid slot: node_a != node_b. A slot with node_a == node_b (including all-zero) is empty and is never a candidate.
- FSM states: IDLE, SCAN, REMOVE.
- IDLE:
  - On start=1, latch edges_in into the buffer, idx<=0, max_btw<=0, found<=0, count<=0, busy<=1, go to SCAN.
  - start while busy is ignored. edges_in is not required to be stable after the accept edge.
- SCAN, one slot per cycle at idx:
  - If the slot is valid, count++.
  - If the slot is valid and (found==0 or btw > max_btw), update max_btw, max_idx and found.
  - Ties keep the lowest index (strict greater-than). A btw of 0 still qualifies if it is the first valid slot.
  - After idx = MAX_EDGES-1, go to REMOVE. idx does not wrap during the scan.
- REMOVE, single cycle:
  - If found, clear slot max_idx to all zeros, drive removed_edge/removed_idx, none_found<=0, edges_left<=count-1.
  - Else none_found<=1, removed_edge<=0, removed_idx<=0, edges_left<=0.
  - edges_out <= buffer with every btw field forced to 0.
  - done<=1, busy<=0, go to IDLE.
- Latency:
  - Start accepted at edge T0; done is high in the cycle after edge T0+MAX_EDGES+1 (edge T9 with defaults).
  - done drops on the following edge.
- Output hold: edges_out, removed_*, none_found and edges_left hold their values until the next REMOVE or reset.
- Back-to-back: start asserted in the cycle done is high is accepted, since the FSM is already in IDLE.
- Arithmetic:
  - Comparison is unsigned on BTW_WIDTH bits.
  - count never exceeds MAX_EDGES. edges_left uses count-1 only when found=1, so it never underflows.

Test Plan:
- Slots {0,1,3},{1,2,5},{2,3,2},{3,0,1}, rest empty; pulse start -> done at T0+9; removed_edge=0x12, removed_idx=1, edges_left=3, slot1=0, other btw fields 0, none_found=0.
- Tie: slots {0,1,7},{2,3,7},{4,5,7} -> removed_idx=0, removed_edge=0x01, edges_left=2.
- All slots empty (edges_in=0) -> done at T0+9, none_found=1, edges_out all 0, edges_left=0.
- Valid edges at slots 5 and 7 only: {1,4,0} and {2,6,0}, all btw 0 -> removed_idx=5, edges_left=1; then start again with that edges_out fed back -> removed_idx=7, edges_left=0.
- Assert rst at T0+4 of a scan -> busy, done and all outputs 0 immediately, no done pulse; a new start after reset completes normally.
- start held high continuously through a scan -> only one done per accepted start; re-accepted in the done cycle, next done 10 cycles later.
